// File: rtl/ct_spsram_ctrl_pkg.sv
// Shared types and constants for the single-port SRAM request controller.
package ct_spsram_ctrl_pkg;

  localparam int RSP_FIFO_DEPTH  = 2;
  localparam int DFLT_ADDR_WIDTH = 10;
  localparam int DFLT_DATA_WIDTH = 59;
  localparam int DFLT_DEPTH      = 1024;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/ct_spsram_rsp_fifo.sv
// Two-entry in-order response FIFO holding {perr, data} words.
module ct_spsram_rsp_fifo
  import ct_spsram_ctrl_pkg::*;
#(
  parameter int W = DFLT_DATA_WIDTH + 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [RSP_FIFO_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         full;

  assign full = (count == 2'(RSP_FIFO_DEPTH));
  assign head = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge CLK) disable iff (RST) push |-> (!full || pop));
  a_no_underflow: assert property (@(posedge CLK) disable iff (RST) pop |-> (count != 2'd0));

endmodule

// File: rtl/ct_spsram_req_ctrl.sv
// Single-port SRAM request controller: zero-fills the array after reset, then
// turns a request stream into SRAM accesses and returns read data in order.
// Optional macro CT_SPSRAM_REQ_CTRL_PARITY_EN makes the MSB an even-parity bit
// over the lower bits (full-word writes only, parity error flag on reads).
//
// Handshakes: a beat transfers on a rising CLK edge where valid && ready.
// req_rdy is computed from registered occupancy only and never looks at
// req_vld; rsp_vld stays high with stable data until rsp_rdy takes the beat.
module ct_spsram_req_ctrl
  import ct_spsram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DFLT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DFLT_DATA_WIDTH,
  parameter int DEPTH      = DFLT_DEPTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_perr,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] A,
  output logic                  CEN,
  output logic                  GWEN,
  output logic [DATA_WIDTH-1:0] WEN,
  output logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] Q,
  output ctrl_state_e           state_dbg
);

  localparam logic [ADDR_WIDTH:0] INIT_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] INIT_STEP = (ADDR_WIDTH+1)'(1);

  ctrl_state_e           state;
  logic [ADDR_WIDTH:0]   init_cnt;
  logic                  rd_inflight;
  logic [ADDR_WIDTH-1:0] a_hold;
  logic [DATA_WIDTH-1:0] d_hold;
  logic [1:0]            fifo_cnt;
  logic                  xfer;
  logic                  rsp_pop;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] wr_wen;
  logic [DATA_WIDTH:0]   fifo_in;
  logic [DATA_WIDTH:0]   fifo_head;

  assign state_dbg = state;

  // A read in flight reserves a FIFO slot so the FIFO can never overflow.
  assign req_rdy = (state == ST_RUN) &&
                   (({1'b0, fifo_cnt} + {2'b00, rd_inflight}) < 3'(RSP_FIFO_DEPTH));
  assign xfer    = req_vld && req_rdy;
  assign rsp_vld = (fifo_cnt != 2'd0);
  assign rsp_pop = rsp_vld && rsp_rdy;
  assign rsp_rdata = fifo_head[DATA_WIDTH-1:0];

`ifdef CT_SPSRAM_REQ_CTRL_PARITY_EN
  logic unused_par_inputs;
  assign unused_par_inputs = ^{req_wmask, req_wdata[DATA_WIDTH-1]};
  assign wr_word  = {^req_wdata[DATA_WIDTH-2:0], req_wdata[DATA_WIDTH-2:0]};
  assign wr_wen   = '0;
  assign fifo_in  = {^Q, Q};
  assign rsp_perr = fifo_head[DATA_WIDTH];
`else
  logic unused_head_perr;
  assign unused_head_perr = fifo_head[DATA_WIDTH];
  assign wr_word  = req_wdata;
  assign wr_wen   = ~req_wmask;
  assign fifo_in  = {1'b0, Q};
  assign rsp_perr = 1'b0;
`endif

  // SRAM pin drive: sweep writes during INIT, request pass-through in RUN.
  always_comb begin
    A    = a_hold;
    D    = d_hold;
    CEN  = 1'b1;
    GWEN = 1'b1;
    WEN  = '1;
    if (state == ST_INIT) begin
      A    = init_cnt[ADDR_WIDTH-1:0];
      D    = '0;
      CEN  = 1'b0;
      GWEN = 1'b0;
      WEN  = '0;
    end else if (xfer) begin
      A    = req_addr;
      D    = wr_word;
      CEN  = 1'b0;
      GWEN = ~req_wr;
      WEN  = wr_wen;
    end
  end

  // Keep A and D stable on idle cycles to avoid needless pin toggling.
  always_ff @(posedge CLK) begin
    a_hold <= A;
    d_hold <= D;
  end

  // Control FSM: zero-fill sweep, then track the one-cycle read latency.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_INIT;
      init_cnt    <= '0;
      init_done   <= 1'b0;
      rd_inflight <= 1'b0;
    end else begin
      rd_inflight <= 1'b0;
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + INIT_STEP;
          if (init_cnt == INIT_LAST) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          rd_inflight <= xfer && !req_wr;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  ct_spsram_rsp_fifo #(
    .W (DATA_WIDTH + 1)
  ) u_rsp_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (rd_inflight),
    .push_data (fifo_in),
    .pop       (rsp_pop),
    .head      (fifo_head),
    .count     (fifo_cnt)
  );

endmodule
